i2s_in_mux: RTL and testbench
=============================

# i2s_in_mux

Merges the 16 per-channel sample streams produced by the I2S receive stage into a single AXI-Stream for the downstream packetiser. Each channel has a one-entry holding register, because the receive stage has no back-pressure input. A round-robin arbiter drains the holding registers into one registered output word tagged with the channel and destination-FPGA index. Lost samples are flagged per channel.

## Interface
Parameters:
- `CH_NUM`, 16: number of I2S channels (1..16).
- `DATA_W`, 32: sample word width.

Ports:
- `mclki` in 1: master clock, 24.576 MHz; the single clock of the block.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tvalid` in CH_NUM: per-channel sample strobe, one cycle per sample; there is no ready.
- `s_axis_tdata` in CH_NUM*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- `s_axis_tlast` in CH_NUM: last slot of the TDM frame.
- `i_enable` in CH_NUM: channel enable.
- `i_dst_fpga_index` in 4*CH_NUM: destination FPGA for channel c, at bits [c*4 +: 4].
- `m_axis_tvalid` out 1: merged stream valid.
- `m_axis_tready` in 1: merged stream ready.
- `m_axis_tdata` out DATA_W: sample.
- `m_axis_tlast` out 1: tlast of the sample.
- `m_axis_tuser` out 8: {dst_fpga_index[3:0], channel[3:0]}.
- `o_overflow` out CH_NUM: sticky per-channel drop flag.
- `i_overflow_clr` in 1: single-cycle clear of the flags (and of the counters, when compiled in).
- `o_ovf_cnt` out 16*CH_NUM: per-channel drop counter; present only with `I2S_IN_MUX_OVF_CNT_EN`.

## Operation
- Holding register per channel: {valid, tdata, tlast}.
  - Load: on `s_axis_tvalid[c]` when the register is empty, or when it is being drained in the same cycle.
  - Overflow: `s_axis_tvalid[c]` while the register is full and not drained this cycle. The new sample is dropped, the oldest is kept, and `o_overflow[c]` is set.
- Disabled channel (`i_enable[c]`=0):
  - Inputs are ignored and the holding register is cleared.
  - A sample already in the output register still completes.
- Round-robin arbiter:
  - Pointer `rr_ptr` (4 bits) resets to 0.
  - Grant goes to the first valid holding register at index rr_ptr, rr_ptr+1, …, wrapping modulo CH_NUM.
  - After a grant to channel g, rr_ptr becomes (g+1) mod CH_NUM.
  - No grant: rr_ptr holds.
- Output register:
  - Loads the granted entry when `!m_axis_tvalid || m_axis_tready`.
  - The granted holding register clears in the same cycle.
  - `tuser` is formed as {i_dst_fpga_index[g], g}, sampled at load.
- AXIS rule: while `m_axis_tvalid && !m_axis_tready`, the values of tdata, tlast and tuser are held stable.
- Flags:
  - `i_overflow_clr` clears all `o_overflow` bits.
  - If an overflow and a clear occur in the same cycle, the set wins.

## Timing
- Reset values (all synchronous):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - `o_overflow`=0, `o_ovf_cnt`=0.
  - All holding registers empty; rr_ptr=0.
- Latency: a sample strobed in cycle N is in the holding register at N+1. With the output empty or ready, `m_axis_tvalid` with that sample is asserted at N+2.
- Throughput: one word per cycle with `m_axis_tready`=1 continuously.
- Drain: all 16 channels strobed in the same cycle drain in 16 consecutive cycles, in order 0..15 from rr_ptr=0.
- Load and drain in the same cycle on the same channel: no overflow; the new sample occupies the register at the next cycle.
- `rst` asserted mid-transfer: the output word is discarded, `m_axis_tvalid` is 0 the next cycle, and pending samples are lost with no flags set.

## Configuration
- `I2S_IN_MUX_OVF_CNT_EN` defined:
  - Per-channel 16-bit drop counters are instantiated on `o_ovf_cnt`.
  - Each counter increments on every overflow event and saturates at 0xFFFF.
  - `i_overflow_clr` clears the counters; an overflow in the same cycle leaves the counter at 1.
- Not defined: the `o_ovf_cnt` port and its logic are absent; only the sticky `o_overflow` flags exist.

## Test plan
- Single sample: ch 3 strobes tdata=0x12345678, tlast=1, dst index of ch 3 = 5, ready=1.
  - Expect exactly one beat 2 cycles later: tdata=0x12345678, tlast=1, tuser=0x53.
- Fairness: all 16 channels strobe simultaneously, ready=1.
  - Expect 16 back-to-back beats with tuser[3:0] = 0..15 in order.
  - A repeat burst starts at channel 0 again (rr_ptr wrapped).
- Back-pressure: ready=0 for 10 cycles with ch 0 and ch 1 pending, then ready=1.
  - Output stays stable on the ch 0 sample while stalled; both samples then delivered, no overflow.
- Overflow: ready=0, ch 2 strobed 3 times.
  - `o_overflow[2]`=1 after the 3rd strobe; the first two samples survive (one in the output register, one held); `o_ovf_cnt[2]`=1 with the macro.
  - Pulse `i_overflow_clr`: flag and counter return to 0.
- Enable and reset: deassert `i_enable[4]` while ch 4 is held; its sample never appears.
  - Assert `rst` while `m_axis_tvalid`=1: next cycle all outputs are 0.

Source files
------------

// File: rtl/i2s_in_mux.sv
// i2s_in_mux: merges per-channel I2S sample strobes into one AXI-Stream.
// Each channel has a one-entry holding register. A round-robin arbiter
// drains these into a registered output word tagged with
// {dst_fpga_index, channel}. Dropped samples set sticky per-channel flags.
// Optional feature: define I2S_IN_MUX_OVF_CNT_EN to add 16-bit saturating
// per-channel drop counters on o_ovf_cnt.
module i2s_in_mux #(
   parameter int CH_NUM = 16,
   parameter int DATA_W = 32
) (
   input  logic                     mclki,
   input  logic                     rst,
   input  logic [CH_NUM-1:0]        s_axis_tvalid,
   input  logic [CH_NUM*DATA_W-1:0] s_axis_tdata,
   input  logic [CH_NUM-1:0]        s_axis_tlast,
   input  logic [CH_NUM-1:0]        i_enable,
   input  logic [4*CH_NUM-1:0]      i_dst_fpga_index,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tlast,
   output logic [7:0]               m_axis_tuser,
   output logic [CH_NUM-1:0]        o_overflow,
   input  logic                     i_overflow_clr
`ifdef I2S_IN_MUX_OVF_CNT_EN
   ,
   output logic [16*CH_NUM-1:0]     o_ovf_cnt
`endif
);

   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [CH_NUM-1:0] hold_valid;
   logic [DATA_W-1:0] hold_data [CH_NUM];
   logic [CH_NUM-1:0] hold_last;
   logic [3:0]        dst_arr   [CH_NUM];
   logic [DATA_W-1:0] in_data   [CH_NUM];

   logic [3:0]        rr_ptr;
   logic [CH_NUM-1:0] req;
   logic              grant_valid;
   logic [3:0]        grant_idx;
   logic [IDX_W-1:0]  grant_sel;
   logic              load_out;
   logic              take;
   logic [CH_NUM-1:0] drain;
   logic [CH_NUM-1:0] ovf;

   for (genvar c = 0; c < CH_NUM; c++) begin : g_unpack
      assign dst_arr[c] = i_dst_fpga_index[c*4 +: 4];
      assign in_data[c] = s_axis_tdata[c*DATA_W +: DATA_W];
   end

   // A disabled channel is never granted, so its held sample cannot escape.
   assign req       = hold_valid & i_enable;
   assign load_out  = !m_axis_tvalid || m_axis_tready;
   assign grant_sel = grant_idx[IDX_W-1:0];
   assign take      = load_out && grant_valid;

   // Round-robin search: first requesting channel at rr_ptr, rr_ptr+1, ...
   always_comb begin
      logic [4:0] sum;
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         sum = {1'b0, rr_ptr} + 5'(i);
         if (sum >= 5'(CH_NUM)) begin
            sum = sum - 5'(CH_NUM);
         end
         if (!grant_valid && req[sum[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = sum[3:0];
         end
      end
   end

   // Drain strobe and overflow detection per channel.
   always_comb begin
      drain = '0;
      ovf   = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         drain[c] = take && (grant_sel == IDX_W'(c));
      end
      ovf = i_enable & s_axis_tvalid & hold_valid & ~drain;
   end

   // Holding registers: load when empty or being drained, clear when disabled.
   always_ff @(posedge mclki) begin
      if (rst) begin
         hold_valid <= '0;
         hold_last  <= '0;
         for (int c = 0; c < CH_NUM; c++) begin
            hold_data[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (!i_enable[c]) begin
               hold_valid[c] <= 1'b0;
            end else if (s_axis_tvalid[c] && (!hold_valid[c] || drain[c])) begin
               hold_valid[c] <= 1'b1;
               hold_data[c]  <= in_data[c];
               hold_last[c]  <= s_axis_tlast[c];
            end else if (drain[c]) begin
               hold_valid[c] <= 1'b0;
            end
         end
      end
   end

   // Arbiter pointer moves past the granted channel, holds otherwise.
   always_ff @(posedge mclki) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (take) begin
         rr_ptr <= (grant_idx == 4'(CH_NUM - 1)) ? 4'd0 : grant_idx + 4'd1;
      end
   end

   // Output register; payload only changes when the slot is free or accepted.
   always_ff @(posedge mclki) begin
      if (rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else if (load_out) begin
         m_axis_tvalid <= grant_valid;
         if (grant_valid) begin
            m_axis_tdata <= hold_data[grant_sel];
            m_axis_tlast <= hold_last[grant_sel];
            m_axis_tuser <= {dst_arr[grant_sel], grant_idx};
         end
      end
   end

   // Sticky drop flags; a new drop in the clear cycle keeps its flag set.
   always_ff @(posedge mclki) begin
      if (rst) begin
         o_overflow <= '0;
      end else begin
         o_overflow <= (i_overflow_clr ? '0 : o_overflow) | ovf;
      end
   end

`ifdef I2S_IN_MUX_OVF_CNT_EN
   logic [15:0] ovf_cnt [CH_NUM];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_cnt_out
      assign o_ovf_cnt[c*16 +: 16] = ovf_cnt[c];
   end

   // Saturating drop counters; a drop in the clear cycle restarts at 1.
   always_ff @(posedge mclki) begin
      if (rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            ovf_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            if (ovf[c]) begin
               if (i_overflow_clr) begin
                  ovf_cnt[c] <= 16'd1;
               end else if (ovf_cnt[c] != 16'hFFFF) begin
                  ovf_cnt[c] <= ovf_cnt[c] + 16'd1;
               end
            end else if (i_overflow_clr) begin
               ovf_cnt[c] <= '0;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_i2s_in_mux.sv
// tb_i2s_in_mux: directed scenarios plus randomized traffic for i2s_in_mux,
// checked every cycle against a transaction-level reference model.
// Build with I2S_IN_MUX_OVF_CNT_EN defined to also check the drop counters.
module tb_i2s_in_mux;

   localparam int CH = 16;
   localparam int DW = 32;

   logic              mclki = 1'b0;
   logic              rst;
   logic [CH-1:0]     s_axis_tvalid;
   logic [CH*DW-1:0]  s_axis_tdata;
   logic [CH-1:0]     s_axis_tlast;
   logic [CH-1:0]     i_enable;
   logic [4*CH-1:0]   i_dst_fpga_index;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tlast;
   logic [7:0]        m_axis_tuser;
   logic [CH-1:0]     o_overflow;
   logic              i_overflow_clr;
`ifdef I2S_IN_MUX_OVF_CNT_EN
   logic [16*CH-1:0]  o_ovf_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit          mhv  [CH];
   logic [31:0] mhd  [CH];
   bit          mhl  [CH];
   int          mptr;
   bit          mov_v;
   logic [31:0] mov_d;
   bit          mov_l;
   logic [7:0]  mov_u;
   logic [CH-1:0] movf;
   int          mcnt [CH];

   always #5 mclki = ~mclki;

   i2s_in_mux #(.CH_NUM(CH), .DATA_W(DW)) dut (
      .mclki            (mclki),
      .rst              (rst),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tlast     (s_axis_tlast),
      .i_enable         (i_enable),
      .i_dst_fpga_index (i_dst_fpga_index),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tuser     (m_axis_tuser),
      .o_overflow       (o_overflow),
      .i_overflow_clr   (i_overflow_clr)
`ifdef I2S_IN_MUX_OVF_CNT_EN
      ,
      .o_ovf_cnt        (o_ovf_cnt)
`endif
   );

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the model, computed from the pre-edge inputs and state.
   function automatic void model_step();
      int g;
      bit ready;
      bit ev;
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            mhv[c] = 0; mcnt[c] = 0;
         end
         mptr = 0; mov_v = 0; mov_d = '0; mov_l = 0; mov_u = '0; movf = '0;
         return;
      end
      ready = !mov_v || m_axis_tready;
      g = -1;
      if (ready) begin
         for (int i = 0; i < CH; i++) begin
            int c;
            c = (mptr + i) % CH;
            if (g < 0 && mhv[c] && i_enable[c]) g = c;
         end
         if (g >= 0) begin
            mov_v = 1; mov_d = mhd[g]; mov_l = mhl[g];
            mov_u = {i_dst_fpga_index[g*4 +: 4], 4'(g)};
         end else begin
            mov_v = 0;
         end
      end
      if (i_overflow_clr) begin
         movf = '0;
         for (int c = 0; c < CH; c++) mcnt[c] = 0;
      end
      for (int c = 0; c < CH; c++) begin
         ev = 0;
         if (!i_enable[c]) begin
            mhv[c] = 0;
         end else if (s_axis_tvalid[c]) begin
            if (!mhv[c] || g == c) begin
               mhv[c] = 1; mhd[c] = s_axis_tdata[c*DW +: DW]; mhl[c] = s_axis_tlast[c];
            end else begin
               ev = 1;
            end
         end else if (g == c) begin
            mhv[c] = 0;
         end
         if (ev) begin
            movf[c] = 1'b1;
            if (mcnt[c] < 65535) mcnt[c]++;
         end
      end
      if (g >= 0) mptr = (g + 1) % CH;
   endfunction

   // Advance one clock and compare every output with the model.
   task automatic tick();
      @(posedge mclki);
      model_step();
      #1;
      check_output("tvalid", 64'(m_axis_tvalid), 64'(mov_v));
      check_output("tdata", 64'(m_axis_tdata), 64'(mov_d));
      check_output("tlast", 64'(m_axis_tlast), 64'(mov_l));
      check_output("tuser", 64'(m_axis_tuser), 64'(mov_u));
      check_output("overflow", 64'(o_overflow), 64'(movf));
`ifdef I2S_IN_MUX_OVF_CNT_EN
      for (int c = 0; c < CH; c++) begin
         check_output($sformatf("ovf_cnt%0d", c), 64'(o_ovf_cnt[c*16 +: 16]), 64'(mcnt[c]));
      end
`endif
   endtask

   task automatic apply_stimulus(input int c, input logic [31:0] d, input logic l);
      s_axis_tvalid[c]         = 1'b1;
      s_axis_tdata[c*DW +: DW] = d;
      s_axis_tlast[c]          = l;
   endtask

   task automatic clear_strobes();
      s_axis_tvalid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int hits;
      rst = 1'b1; s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
      i_enable = '1; m_axis_tready = 1'b1; i_overflow_clr = 1'b0;
      i_dst_fpga_index = {$urandom, $urandom};
      i_dst_fpga_index[3*4 +: 4] = 4'd5;
      do_reset();
      check_output("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_output("rst_tuser", 64'(m_axis_tuser), 64'd0);
      check_output("rst_overflow", 64'(o_overflow), 64'd0);

      // Single sample on channel 3
      apply_stimulus(3, 32'h12345678, 1'b1);
      tick();
      clear_strobes();
      check_output("single_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick();
      check_output("single_tvalid", 64'(m_axis_tvalid), 64'd1);
      check_output("single_tdata", 64'(m_axis_tdata), 64'h12345678);
      check_output("single_tlast", 64'(m_axis_tlast), 64'd1);
      check_output("single_tuser", 64'(m_axis_tuser), 64'h53);
      tick();
      check_output("single_after", 64'(m_axis_tvalid), 64'd0);

      // Fairness: all channels at once, drained in index order
      do_reset();
      for (int c = 0; c < CH; c++) apply_stimulus(c, 32'hA000_0000 | c, 1'(c == CH - 1));
      tick();
      clear_strobes();
      for (int i = 0; i < CH; i++) begin
         tick();
         check_output($sformatf("fair_valid%0d", i), 64'(m_axis_tvalid), 64'd1);
         check_output($sformatf("fair_ch%0d", i), 64'(m_axis_tuser[3:0]), 64'(i));
      end
      for (int c = 0; c < CH; c++) apply_stimulus(c, 32'hB000_0000 | c, 1'b0);
      tick();
      clear_strobes();
      tick();
      check_output("fair_wrap_ch", 64'(m_axis_tuser[3:0]), 64'd0);
      for (int i = 0; i < CH + 2; i++) tick();

      // Back-pressure with channels 0 and 1 pending
      m_axis_tready = 1'b0;
      apply_stimulus(0, 32'hC0C0_0000, 1'b0);
      apply_stimulus(1, 32'hC1C1_1111, 1'b1);
      tick();
      clear_strobes();
      for (int k = 0; k < 10; k++) begin
         tick();
         check_output("bp_stall_valid", 64'(m_axis_tvalid), 64'd1);
         check_output("bp_stall_data", 64'(m_axis_tdata), 64'hC0C0_0000);
      end
      m_axis_tready = 1'b1;
      tick();
      check_output("bp_ch1_data", 64'(m_axis_tdata), 64'hC1C1_1111);
      tick();
      check_output("bp_done", 64'(m_axis_tvalid), 64'd0);
      check_output("bp_no_ovf", 64'(o_overflow), 64'd0);

      // Overflow: channel 2 strobed three times while stalled
      m_axis_tready = 1'b0;
      apply_stimulus(2, 32'hAAAA_0001, 1'b0); tick();
      apply_stimulus(2, 32'hBBBB_0002, 1'b0); tick();
      apply_stimulus(2, 32'hCCCC_0003, 1'b0); tick();
      clear_strobes();
      check_output("ovf_flag2", 64'(o_overflow), 64'h4);
      check_output("ovf_first", 64'(m_axis_tdata), 64'hAAAA_0001);
`ifdef I2S_IN_MUX_OVF_CNT_EN
      check_output("ovf_cnt2", 64'(o_ovf_cnt[2*16 +: 16]), 64'd1);
`endif
      m_axis_tready = 1'b1;
      tick();
      check_output("ovf_second", 64'(m_axis_tdata), 64'hBBBB_0002);
      tick();
      check_output("ovf_empty", 64'(m_axis_tvalid), 64'd0);
      i_overflow_clr = 1'b1;
      tick();
      i_overflow_clr = 1'b0;
      check_output("ovf_clr", 64'(o_overflow), 64'd0);
`ifdef I2S_IN_MUX_OVF_CNT_EN
      check_output("ovf_cnt_clr", 64'(o_ovf_cnt[2*16 +: 16]), 64'd0);
`endif

      // Disabling channel 4 while it is held discards its sample
      m_axis_tready = 1'b0;
      apply_stimulus(3, 32'h3333_3333, 1'b0);
      apply_stimulus(4, 32'hDEAD_0004, 1'b0);
      tick();
      clear_strobes();
      tick();
      i_enable[4] = 1'b0;
      tick();
      i_enable[4] = 1'b1;
      m_axis_tready = 1'b1;
      hits = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (m_axis_tvalid && m_axis_tuser[3:0] == 4'd4) hits++;
      end
      check_output("disable_ch4_beats", 64'(hits), 64'd0);

      // Reset while a word is waiting at the output
      m_axis_tready = 1'b0;
      apply_stimulus(7, 32'h7777_7777, 1'b1);
      apply_stimulus(8, 32'h8888_8888, 1'b0);
      tick();
      clear_strobes();
      tick();
      check_output("mid_rst_pre", 64'(m_axis_tvalid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check_output("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
      check_output("mid_rst_tlast", 64'(m_axis_tlast), 64'd0);
      check_output("mid_rst_tuser", 64'(m_axis_tuser), 64'd0);
      m_axis_tready = 1'b1;
      tick();
      tick();
      check_output("mid_rst_lost", 64'(m_axis_tvalid), 64'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         s_axis_tvalid = CH'($urandom & $urandom);
         for (int c = 0; c < CH; c++) s_axis_tdata[c*DW +: DW] = $urandom;
         s_axis_tlast = CH'($urandom);
         m_axis_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) i_enable = CH'($urandom | $urandom);
         else if ($urandom_range(0, 15) == 0) i_enable = '1;
         if ($urandom_range(0, 63) == 0) i_dst_fpga_index = {$urandom, $urandom};
         i_overflow_clr = ($urandom_range(0, 31) == 0);
         rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0; clear_strobes(); i_overflow_clr = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
